// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - NCH-channel round-robin write-bus arbiter with burst hold and registered output stage
module bus_arbiter #(
  parameter int NCH  = 4,
  parameter int BAW  = 32,
  parameter int BDW  = 32,
  parameter int HOLD = 1,
  localparam int CW  = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     s_wvalid,
  output logic [NCH-1:0]     s_wready,
  input  logic [NCH*BAW-1:0] s_waddr,
  input  logic [NCH*BDW-1:0] s_wdata,
  output logic               m_wvalid,
  input  logic               m_wready,
  output logic [BAW-1:0]     m_waddr,
  output logic [BDW-1:0]     m_wdata,
  output logic [CW-1:0]      m_wsel
);

  localparam int HW = $clog2(HOLD + 1);
  localparam int IW = CW + 1;

  typedef enum logic {EMPTY, FULL} ostate_t;

  ostate_t       state, state_nxt;
  logic [CW-1:0] last;
  logic [CW-1:0] win;
  logic [HW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          burst;
  logic          found;
  logic          load;
  logic          accept;

  // cnt==0 only after reset, when no channel owns a burst yet, so the scan starts at channel 0.
  always_comb begin
    burst = s_wvalid[last] && (cnt != '0) && (cnt < HW'(HOLD));
    win   = last;
    found = 1'b0;
    idx   = '0;
    if (burst) begin
      found = 1'b1;
    end else begin
      for (int i = 1; i <= NCH; i++) begin
        idx = {1'b0, last} + IW'(i);
        if (idx >= IW'(NCH)) idx = idx - IW'(NCH);
        if (!found && s_wvalid[idx[CW-1:0]]) begin
          found = 1'b1;
          win   = idx[CW-1:0];
        end
      end
    end
  end

  assign load   = (state == EMPTY) || m_wready;
  assign accept = load && found && !rst;

  always_comb begin
    s_wready = '0;
    if (accept) s_wready[win] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (m_wready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  assign m_wvalid = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_waddr <= '0;
      m_wdata <= '0;
      m_wsel  <= '0;
    end else if (accept) begin
      m_waddr <= s_waddr[win*BAW +: BAW];
      m_wdata <= s_wdata[win*BDW +: BDW];
      m_wsel  <= win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= CW'(NCH - 1);
      cnt  <= '0;
    end else if (accept) begin
      last <= win;
      if (win != last)               cnt <= HW'(1);
      else if (cnt < HW'(HOLD))      cnt <= cnt + HW'(1);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter with HOLD=1 and HOLD=3 instances
module tb_bus_arbiter;

  localparam int NCH = 4;
  localparam int BAW = 16;
  localparam int BDW = 16;
  localparam int CW  = 2;

  logic               clk;
  logic               rst;
  logic [NCH-1:0]     vld  [2];
  logic [NCH-1:0]     srdy [2];
  logic [NCH*BAW-1:0] sa   [2];
  logic [NCH*BDW-1:0] sd   [2];
  logic               mrdy [2];
  logic               mv   [2];
  logic [BAW-1:0]     ma   [2];
  logic [BDW-1:0]     md   [2];
  logic [CW-1:0]      ms   [2];

  bus_arbiter #(.NCH(NCH), .BAW(BAW), .BDW(BDW), .HOLD(1)) u_h1 (
    .clk(clk), .rst(rst),
    .s_wvalid(vld[0]), .s_wready(srdy[0]), .s_waddr(sa[0]), .s_wdata(sd[0]),
    .m_wvalid(mv[0]), .m_wready(mrdy[0]), .m_waddr(ma[0]), .m_wdata(md[0]), .m_wsel(ms[0])
  );

  bus_arbiter #(.NCH(NCH), .BAW(BAW), .BDW(BDW), .HOLD(3)) u_h3 (
    .clk(clk), .rst(rst),
    .s_wvalid(vld[1]), .s_wready(srdy[1]), .s_waddr(sa[1]), .s_wdata(sd[1]),
    .m_wvalid(mv[1]), .m_wready(mrdy[1]), .m_waddr(ma[1]), .m_wdata(md[1]), .m_wsel(ms[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [BAW-1:0] a;
    logic [BDW-1:0] d;
    logic [CW-1:0]  s;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  int    hold      [2];
  int    ml        [2];
  int    mc        [2];
  bit    mf        [2];
  int    last_acc  [2];
  int    delivered [2];
  int    waitg     [2][NCH];
  int    seq       [2][NCH];
  int    n_assert;
  int    n_fail;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(int k);
    int l;
    l = ml[k];
    if (vld[k][l] && mc[k] > 0 && mc[k] < hold[k]) return l;
    for (int s = 1; s <= NCH; s++)
      if (vld[k][(l + s) % NCH]) return (l + s) % NCH;
    return -1;
  endfunction

  task automatic q_check(int k, bit pop);
    item_t it;
    int    sz;
    sz = (k == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      chk($sformatf("sb_underflow%0d", k), 32'(mv[k]), 32'd0);
    end else begin
      it = (k == 0) ? q0[0] : q1[0];
      chk($sformatf("m_waddr%0d", k), 32'(ma[k]), 32'(it.a));
      chk($sformatf("m_wdata%0d", k), 32'(md[k]), 32'(it.d));
      chk($sformatf("m_wsel%0d", k), 32'(ms[k]), 32'(it.s));
      if (pop) begin
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        delivered[k]++;
      end
    end
  endtask

  task automatic evaluate(int k);
    int             w;
    bit             load;
    logic [NCH-1:0] er;
    item_t          it;
    if (rst) begin
      chk($sformatf("rst_srdy%0d", k), 32'(srdy[k]), 32'd0);
      ml[k] = NCH - 1;
      mc[k] = 0;
      mf[k] = 1'b0;
      last_acc[k] = -1;
      for (int c = 0; c < NCH; c++) waitg[k][c] = 0;
      if (k == 0) q0.delete();
      else        q1.delete();
      return;
    end
    w    = pick(k);
    load = !mf[k] || mrdy[k];
    er   = '0;
    if (load && w >= 0) er[w] = 1'b1;
    chk($sformatf("s_wready%0d", k), 32'(srdy[k]), 32'(er));
    chk($sformatf("m_wvalid%0d", k), 32'(mv[k]), 32'(mf[k]));
    if (mf[k]) q_check(k, mrdy[k]);
    last_acc[k] = -1;
    if (load && w >= 0) begin
      it.a = sa[k][w*BAW +: BAW];
      it.d = sd[k][w*BDW +: BDW];
      it.s = CW'(w);
      if (k == 0) q0.push_back(it);
      else        q1.push_back(it);
      chk($sformatf("starve%0d", k), 32'(waitg[k][w] <= (NCH - 1) * hold[k]), 32'd1);
      for (int c = 0; c < NCH; c++) begin
        if (c == w || !vld[k][c]) waitg[k][c] = 0;
        else                      waitg[k][c]++;
      end
      if (w == ml[k]) mc[k] = (mc[k] + 1 > hold[k]) ? hold[k] : mc[k] + 1;
      else            mc[k] = 1;
      ml[k] = w;
      mf[k] = 1'b1;
      last_acc[k] = w;
    end else if (mrdy[k]) begin
      mf[k] = 1'b0;
    end
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic adv();
    evaluate(0);
    evaluate(1);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic set_ch(int k, int ch, logic v, logic [BAW-1:0] a, logic [BDW-1:0] d);
    vld[k][ch] = v;
    sa[k][ch*BAW +: BAW] = a;
    sd[k][ch*BDW +: BDW] = d;
  endtask

  task automatic set_all(int k, logic [NCH-1:0] v);
    for (int c = 0; c < NCH; c++) set_ch(k, c, v[c], BAW'(16'h0100 + c), BDW'(16'hD000 + c));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_drive(int k);
    for (int c = 0; c < NCH; c++) begin
      if (last_acc[k] == c) seq[k][c]++;
      if (last_acc[k] == c || !vld[k][c])
        set_ch(k, c, ($urandom_range(0, 2) != 0), BAW'(c * 4096 + (seq[k][c] % 4096)), BDW'($urandom));
    end
    mrdy[k] = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int exp3 [7];
    int cyc;
    exp3 = '{0, 0, 0, 1, 1, 1, 0};
    n_assert = 0;
    n_fail   = 0;
    hold     = '{1, 3};
    for (int k = 0; k < 2; k++) begin
      vld[k] = '0; sa[k] = '0; sd[k] = '0; mrdy[k] = 1'b0;
      delivered[k] = 0;
      for (int c = 0; c < NCH; c++) seq[k][c] = 0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    settle();
    for (int k = 0; k < 2; k++) begin
      chk("reset_m_wvalid", 32'(mv[k]), 32'd0);
      chk("reset_m_waddr", 32'(ma[k]), 32'd0);
      chk("reset_m_wdata", 32'(md[k]), 32'd0);
      chk("reset_m_wsel", 32'(ms[k]), 32'd0);
    end
    adv();

    // single writer on channel 2
    set_ch(0, 2, 1'b1, 16'h0010, 16'h00A5);
    mrdy[0] = 1'b1;
    settle();
    chk("t1_s_wready", 32'(srdy[0]), 32'h4);
    adv();
    set_ch(0, 2, 1'b0, 16'h0010, 16'h00A5);
    settle();
    chk("t1_m_wvalid", 32'(mv[0]), 32'd1);
    chk("t1_m_waddr", 32'(ma[0]), 32'h10);
    chk("t1_m_wdata", 32'(md[0]), 32'hA5);
    chk("t1_m_wsel", 32'(ms[0]), 32'd2);
    adv();
    tick();

    // pure round-robin, all channels requesting
    do_reset();
    set_all(0, 4'b1111);
    mrdy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("t2_order", 32'(srdy[0]), 32'(1 << (i % 4)));
      adv();
    end
    set_all(0, 4'b0000);
    tick();
    tick();

    // HOLD=3 bursts, then holder drops valid
    do_reset();
    set_all(1, 4'b0011);
    mrdy[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      settle();
      chk("t3_order", 32'(srdy[1]), 32'(1 << exp3[i]));
      adv();
    end
    set_all(1, 4'b0010);
    settle();
    chk("t3_drop", 32'(srdy[1]), 32'h2);
    adv();
    set_all(1, 4'b0000);
    tick();
    tick();

    // downstream stall with all channels requesting
    set_all(0, 4'b1111);
    mrdy[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (i > 0) chk("t4_stall_srdy", 32'(srdy[0]), 32'd0);
      adv();
    end
    mrdy[0] = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    set_all(0, 4'b0000);
    tick();
    tick();

    // reset while full and stalled
    set_all(0, 4'b1111);
    mrdy[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    settle();
    chk("t5_rst_srdy", 32'(srdy[0]), 32'd0);
    adv();
    rst = 1'b0;
    settle();
    chk("t5_m_wvalid", 32'(mv[0]), 32'd0);
    chk("t5_first_grant", 32'(srdy[0]), 32'h1);
    adv();
    set_all(0, 4'b0000);
    mrdy[0] = 1'b1;
    tick();
    tick();

    // random traffic on both instances
    delivered[0] = 0;
    delivered[1] = 0;
    cyc = 0;
    while ((delivered[0] < 10000 || delivered[1] < 10000) && cyc < 40000) begin
      rand_drive(0);
      rand_drive(1);
      tick();
      cyc++;
    end
    chk("t6_done", 32'(delivered[0] >= 10000 && delivered[1] >= 10000), 32'd1);
    for (int k = 0; k < 2; k++) begin
      vld[k]  = '0;
      mrdy[k] = 1'b1;
    end
    tick();
    tick();
    tick();
    chk("t6_q0_drained", 32'(q0.size()), 32'd0);
    chk("t6_q1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
